cc_unit: RTL and testbench
==========================

Name: cc_unit

Overview:
- Consumer end of the execute-stage ALU interface in the Y86-64 pipeline.
- Accepts ALU results (ans, overflow, operation code) through a valid/ready handshake and derives ZF/SF/OF.
- Holds the derived flags in a one-entry pending stage, then commits them to the architectural condition-code register.
- Answers cmovXX/jXX condition queries (ifun) with a registered cond bit; the execute/fetch logic uses it for branch resolution and conditional moves.

Parameters:
- WIDTH, 64, data width of the ALU result.
- CC_RESET, 3'b100, CC value {ZF,SF,OF} after reset (Y86 convention: ZF=1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- alu_valid  in  1  ALU result presented.
- alu_ready  out  1  unit can accept the ALU result.
- alu_ans  in  WIDTH  signed ALU result.
- alu_overflow  in  1  ALU overflow flag.
- alu_control  in  2  ALU op: 00 add, 01 sub, 10 and, 11 xor.
- set_cc  in  1  this result updates the CC (OPq only).
- stall  in  1  holds the pending stage and freezes the query output.
- suppress_cc  in  1  later-stage exception; discards the pending update.
- cond_valid  in  1  condition query presented.
- cond_ready  out  1  query can be accepted.
- cond_ifun  in  4  Y86 condition: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g.
- cond_out  out  1  evaluated condition.
- cond_out_valid  out  1  cond_out valid this cycle (one-cycle pulse per query).
- cond_err  out  1  query had ifun > 6 (pulse, aligned with cond_out_valid).
- cc_out  out  3  architectural {ZF,SF,OF}.

Behaviour:
- Reset (rst_n=0 at the edge):
  - cc_out=CC_RESET; pend_valid=0.
  - cond_out, cond_out_valid, cond_err = 0.
  - alu_ready and cond_ready are forced 0 while rst_n=0.
- Flag derivation, done at capture:
  - ZF = (alu_ans==0).
  - SF = alu_ans[WIDTH-1].
  - OF = alu_overflow when alu_control is 00 or 01; OF = 0 for 10 and 11 regardless of the input.
- Capture: alu_valid & alu_ready & set_cc loads the pending regs and sets pend_valid.
  - alu_valid & alu_ready & !set_cc is accepted and dropped; no state change.
- Commit: the cycle after capture, if pend_valid & !stall:
  - suppress_cc=0: CC <= pending flags.
  - suppress_cc=1: CC unchanged, pending discarded.
  - Either way pend_valid <= 0 unless a new capture happens in the same cycle.
- Stall with pend_valid=1: pending held, CC unchanged. suppress_cc is sampled only in the commit cycle.
- alu_ready = rst_n & !(pend_valid & stall). Back-to-back captures with no stall give a CC update every cycle; commit and new capture occur on the same edge.
- Latency: ALU result accepted in cycle N; cc_out reflects it in N+1.
- Query: cond_valid & cond_ready in cycle N produces cond_out/cond_out_valid/cond_err registered in N+1.
  - Evaluation against {ZF,SF,OF}:
    - always → 1
    - le → (SF^OF)|ZF
    - l → SF^OF
    - e → ZF
    - ne → !ZF
    - ge → !(SF^OF)
    - g → !(SF^OF)&!ZF
    - ifun 7–15 → cond_out=0, cond_err=1.
  - A query with ifun=0 is always ready, independent of pending state.
- cond_ready = rst_n & !stall & !pend_valid. This is the baseline; see the optional feature for the forwarded case.
- Stall freezes cond_out/cond_out_valid at their current values; no new pulse is generated.
- Reset mid-update: a pending entry is dropped and CC returns to CC_RESET.

Optional Feature:
- Macro: CC_FORWARD_EN.
- Defined:
  - cond_ready = rst_n & !stall; queries are not blocked by pend_valid.
  - When pend_valid & !suppress_cc, the query evaluates against the pending flags (bypass).
  - When suppress_cc=1 in that cycle, the query evaluates against the current CC.
- Undefined: queries wait one cycle behind any pending update (baseline rule above). Results are identical; only throughput differs.

Decomposition:
- Shared package y86_pkg:
  - ALU op constants (ALU_ADD=2'b00, ALU_SUB, ALU_AND, ALU_XOR).
  - Condition codes (C_ALWAYS..C_G).
  - Flag bit indices (CC_ZF=2, CC_SF=1, CC_OF=0).
  - CC_RESET default.
- One sub-module: cond_eval, combinational {ZF,SF,OF} + ifun → {cond, err}. It is reused by the fetch/branch logic.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles → cc_out=3'b100, cond_out_valid=0, alu_ready=0; after release alu_ready=1.
- Sub result with flags: alu_ans=-5 (sub), alu_overflow=0, set_cc=1 → next cycle cc_out=3'b010; query ifun=2 (l) → cond_out=1; query ifun=6 (g) → cond_out=0.
- Logical-op OF clear: alu_control=11, alu_ans=0, alu_overflow=1, set_cc=1 → cc_out=3'b100 (OF cleared); query ifun=3 → cond_out=1.
- Suppress and stall:
  - Capture add result 7, then hold stall=1 for 2 cycles → alu_ready=0 and cc_out unchanged during the stall.
  - Release the stall with suppress_cc=1 → cc_out unchanged, pend cleared.
- Back-to-back and invalid ifun:
  - Three consecutive set_cc results with ans 0, -1, 1 → cc_out sequence 100, 010, 000 on consecutive cycles.
  - Query ifun=9 → cond_out=0, cond_err=1.
- Forwarding check:
  - With CC_FORWARD_EN: query ifun=3 issued the cycle after capturing ans=0 → cond_ready=1, cond_out=1 the following cycle.
  - Without the macro: the same query waits one cycle with cond_ready=0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: ALU op codes, condition codes, CC bit layout.
// Imported by the execute-stage condition-code logic and by fetch/branch.
package y86_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET_DEF = 3'b100;

endpackage

// File: rtl/cc_unit_if.sv
// ALU-result and condition-query handshakes between execute and cc_unit.
// master = execute/fetch side, slave = cc_unit.
interface cc_unit_if #(
  parameter int WIDTH = 64
);

  logic             alu_valid;
  logic             alu_ready;
  logic [WIDTH-1:0] alu_ans;
  logic             alu_overflow;
  logic [1:0]       alu_control;
  logic             set_cc;

  logic             cond_valid;
  logic             cond_ready;
  logic [3:0]       cond_ifun;
  logic             cond_out;
  logic             cond_out_valid;
  logic             cond_err;

  modport master (
    output alu_valid, alu_ans, alu_overflow,
    output alu_control, set_cc,
    output cond_valid, cond_ifun,
    input  alu_ready, cond_ready,
    input  cond_out, cond_out_valid, cond_err
  );

  modport slave (
    input  alu_valid, alu_ans, alu_overflow,
    input  alu_control, set_cc,
    input  cond_valid, cond_ifun,
    output alu_ready, cond_ready,
    output cond_out, cond_out_valid, cond_err
  );

endinterface

// File: rtl/cc_unit_cond_eval.sv
// Combinational Y86 condition evaluation: {ZF,SF,OF} + ifun -> cond/err.
// Shared with the fetch/branch logic.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cond,
  output logic       err
);

  logic zf;
  logic sf;
  logic of_;
  logic lt;

  assign zf  = cc[CC_ZF];
  assign sf  = cc[CC_SF];
  assign of_ = cc[CC_OF];
  assign lt  = sf ^ of_;

  always_comb begin
    cond = 1'b0;
    err  = 1'b0;
    case (ifun)
      C_ALWAYS: cond = 1'b1;
      C_LE:     cond = lt | zf;
      C_L:      cond = lt;
      C_E:      cond = zf;
      C_NE:     cond = !zf;
      C_GE:     cond = !lt;
      C_G:      cond = !lt & !zf;
      default:  err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/cc_unit.sv
// Y86-64 condition-code unit: pending flag stage, CC commit, cond queries.
// Build option CC_FORWARD_EN lets queries bypass a pending CC update.
module cc_unit
  import y86_pkg::*;
#(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = CC_RESET_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  cc_unit_if.slave   bus,
  input  logic       stall,
  input  logic       suppress_cc,
  output logic [2:0] cc_out
);

  logic [2:0] cc;
  logic [2:0] pend;
  logic       pend_valid;
  logic [2:0] flags;
  logic       capture;
  logic       commit;
  logic       q_fire;
  logic [2:0] eval_cc;
  logic       eval_cond;
  logic       eval_err;

  assign flags[CC_ZF] = (bus.alu_ans == '0);
  assign flags[CC_SF] = bus.alu_ans[WIDTH-1];
  // Logical ops never overflow; only add/sub pass the ALU flag through.
  assign flags[CC_OF] = bus.alu_overflow & !bus.alu_control[1];

  assign bus.alu_ready = rst_n & !(pend_valid & stall);
  assign capture = bus.alu_valid & bus.alu_ready & bus.set_cc;
  assign commit  = pend_valid & !stall;

`ifdef CC_FORWARD_EN
  assign bus.cond_ready = rst_n & !stall;
  assign eval_cc = (pend_valid & !suppress_cc) ? pend : cc;
`else
  assign bus.cond_ready = rst_n & !stall &
    (!pend_valid | (bus.cond_ifun == C_ALWAYS));
  assign eval_cc = cc;
`endif

  assign q_fire = bus.cond_valid & bus.cond_ready;

  cond_eval u_eval (
    .cc   (eval_cc),
    .ifun (bus.cond_ifun),
    .cond (eval_cond),
    .err  (eval_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc         <= CC_RESET;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (commit & !suppress_cc)
        cc <= pend;
      if (capture) begin
        pend       <= flags;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.cond_out       <= 1'b0;
      bus.cond_out_valid <= 1'b0;
      bus.cond_err       <= 1'b0;
    end else if (!stall) begin
      bus.cond_out       <= q_fire & eval_cond;
      bus.cond_out_valid <= q_fire;
      bus.cond_err       <= q_fire & eval_err;
    end
  end

  assign cc_out = cc;

endmodule

// File: tb/tb_cc_unit.sv
// Directed bench for cc_unit: flag table plus stall/suppress/reset cases.
// Follows the CC_FORWARD_EN build option for the query-throughput case.
module tb_cc_unit;

  localparam int W = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic       suppress_cc;
  logic [2:0] cc_out;

  int checks = 0;
  int errors = 0;

  cc_unit_if #(.WIDTH(W)) bus ();

  cc_unit #(.WIDTH(W), .CC_RESET(3'b100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .stall       (stall),
    .suppress_cc (suppress_cc),
    .cc_out      (cc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] ans;
    logic [1:0]   ctrl;
    logic         ovf;
    logic [3:0]   ifun;
    logic [2:0]   cc;
    logic         cond;
    logic         err;
  } vec_t;

  vec_t tv [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_alu(input logic [W-1:0] ans, input logic [1:0] ctrl,
                           input logic ovf, input logic sc);
    bus.alu_valid    = 1'b1;
    bus.alu_ans      = ans;
    bus.alu_control  = ctrl;
    bus.alu_overflow = ovf;
    bus.set_cc       = sc;
  endtask

  task automatic idle_alu();
    bus.alu_valid = 1'b0;
    bus.set_cc    = 1'b0;
  endtask

  initial begin
    tv[0] = '{64'hFFFF_FFFF_FFFF_FFFB, 2'b01, 1'b0, 4'd2, 3'b010, 1'b1, 1'b0};
    tv[1] = '{64'hFFFF_FFFF_FFFF_FFFB, 2'b01, 1'b0, 4'd6, 3'b010, 1'b0, 1'b0};
    tv[2] = '{64'h0,                   2'b11, 1'b1, 4'd3, 3'b100, 1'b1, 1'b0};
    tv[3] = '{64'h5,                   2'b00, 1'b1, 4'd1, 3'b001, 1'b1, 1'b0};
    tv[4] = '{64'h8000_0000_0000_0000, 2'b00, 1'b1, 4'd5, 3'b011, 1'b1, 1'b0};
    tv[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b1, 4'd4, 3'b010, 1'b1, 1'b0};
    tv[6] = '{64'h0,                   2'b01, 1'b0, 4'd0, 3'b100, 1'b1, 1'b0};
    tv[7] = '{64'h1,                   2'b00, 1'b0, 4'd9, 3'b000, 1'b0, 1'b1};
    tv[8] = '{64'h3,                   2'b01, 1'b0, 4'd6, 3'b000, 1'b1, 1'b0};
    tv[9] = '{64'hFFFF_FFFF_FFFF_FFFE, 2'b01, 1'b1, 4'd2, 3'b011, 1'b0, 1'b0};

    rst_n = 1'b0;
    stall = 1'b0;
    suppress_cc = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_ans = '0;
    bus.alu_overflow = 1'b0;
    bus.alu_control = 2'b00;
    bus.set_cc = 1'b0;
    bus.cond_valid = 1'b0;
    bus.cond_ifun = 4'd0;

    // reset
    step();
    step();
    chk("rst_cc", cc_out, 3'b100);
    chk("rst_outv", bus.cond_out_valid, 1'b0);
    chk("rst_alu_ready", bus.alu_ready, 1'b0);
    chk("rst_cond_ready", bus.cond_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_alu_ready", bus.alu_ready, 1'b1);
    step();

    // flag/condition table
    for (int i = 0; i < 10; i++) begin
      drive_alu(tv[i].ans, tv[i].ctrl, tv[i].ovf, 1'b1);
      step();
      idle_alu();
      step();
      chk($sformatf("tv%0d_cc", i), cc_out, tv[i].cc);
      bus.cond_valid = 1'b1;
      bus.cond_ifun  = tv[i].ifun;
      #1;
      chk($sformatf("tv%0d_qready", i), bus.cond_ready, 1'b1);
      step();
      bus.cond_valid = 1'b0;
      chk($sformatf("tv%0d_outv", i), bus.cond_out_valid, 1'b1);
      chk($sformatf("tv%0d_cond", i), bus.cond_out, tv[i].cond);
      chk($sformatf("tv%0d_err", i), bus.cond_err, tv[i].err);
    end

    // stall freezes the query pulse
    stall = 1'b1;
    step();
    chk("frz_outv", bus.cond_out_valid, 1'b1);
    stall = 1'b0;
    step();
    chk("frz_rel_outv", bus.cond_out_valid, 1'b0);

    // back-to-back captures, cc starts at 011
    drive_alu(64'h0, 2'b00, 1'b0, 1'b1);
    step();
    drive_alu(64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 1'b1);
    step();
    chk("b2b_0", cc_out, 3'b100);
    drive_alu(64'h1, 2'b00, 1'b0, 1'b1);
    step();
    chk("b2b_1", cc_out, 3'b010);
    idle_alu();
    step();
    chk("b2b_2", cc_out, 3'b000);

    // accepted without set_cc: dropped
    drive_alu(64'h0, 2'b01, 1'b1, 1'b0);
    #1;
    chk("noset_ready", bus.alu_ready, 1'b1);
    step();
    idle_alu();
    step();
    chk("noset_cc", cc_out, 3'b000);

    // query right behind a pending ans=0 update
    drive_alu(64'h0, 2'b00, 1'b0, 1'b1);
    step();
    idle_alu();
    bus.cond_valid = 1'b1;
    bus.cond_ifun  = 4'd3;
    #1;
`ifdef CC_FORWARD_EN
    chk("fwd_qready", bus.cond_ready, 1'b1);
    step();
`else
    chk("fwd_qblock", bus.cond_ready, 1'b0);
    step();
    chk("fwd_qready", bus.cond_ready, 1'b1);
    step();
`endif
    bus.cond_valid = 1'b0;
    chk("fwd_outv", bus.cond_out_valid, 1'b1);
    chk("fwd_cond", bus.cond_out, 1'b1);

    // stall then suppressed commit, cc starts at 100
    drive_alu(64'h7, 2'b00, 1'b0, 1'b1);
    step();
    idle_alu();
    stall = 1'b1;
    #1;
    chk("stl_ready0", bus.alu_ready, 1'b0);
    chk("stl_cc0", cc_out, 3'b100);
    step();
    chk("stl_ready1", bus.alu_ready, 1'b0);
    chk("stl_cc1", cc_out, 3'b100);
    step();
    stall = 1'b0;
    suppress_cc = 1'b1;
    step();
    suppress_cc = 1'b0;
    chk("sup_cc", cc_out, 3'b100);
    #1;
    chk("sup_alu_ready", bus.alu_ready, 1'b1);
    chk("sup_cond_ready", bus.cond_ready, 1'b1);
    step();
    chk("sup_cc_hold", cc_out, 3'b100);

    // reset while an update is pending
    drive_alu(64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 1'b1);
    step();
    idle_alu();
    rst_n = 1'b0;
    step();
    chk("mid_rst_cc", cc_out, 3'b100);
    rst_n = 1'b1;
    step();
    step();
    chk("mid_rst_drop", cc_out, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
